// File: rtl/rgmii_idelay_pkg.sv
// Shared types and constants for the RGMII IDELAY tap controller.
package rgmii_idelay_pkg;

    localparam int NLANES = 5;
    localparam int TAP_W  = 5;
    localparam int LANE_W = 3;
    localparam logic [LANE_W-1:0] LANE_CTL = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_LANE     = 2'd3
    } err_t;

    function automatic logic [NLANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        logic [NLANES-1:0] one;
        one = {{(NLANES-1){1'b0}}, 1'b1};
        return one << lane;
    endfunction

endpackage

// File: rtl/rgmii_idelay_ctl_if.sv
// Command handshake between a tap-tuning master and rgmii_idelay_ctl.
interface rgmii_idelay_ctl_if;
    import rgmii_idelay_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [LANE_W-1:0] cmd_lane;
    logic [TAP_W-1:0]  cmd_value;

    modport master (output cmd_valid, output cmd_lane, output cmd_value, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_lane, input cmd_value, output cmd_ready);
endinterface

// File: rtl/idelay_timer.sv
// Loadable saturating down-counter with a zero flag.
module idelay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rgmii_idelay_ctl.sv
// Loads one IDELAY tap per command and verifies it by readback.
// Optional tap sweep (0..31 on one lane) enabled by defining RGMII_IDELAY_SWEEP_EN.
module rgmii_idelay_ctl
    import rgmii_idelay_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int RDY_TIMEOUT   = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                idelayctrl_rdy,
    rgmii_idelay_ctl_if.slave   cmd,
    output logic [NLANES-1:0]   idelay_ld,
    output logic [TAP_W-1:0]    idelay_value_in,
    output logic [LANE_W-1:0]   idelay_sel,
    input  logic [TAP_W-1:0]    idelay_value_out_data,
    input  logic [TAP_W-1:0]    idelay_value_out_ctl,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic [TAP_W-1:0]    readback
`ifdef RGMII_IDELAY_SWEEP_EN
    ,
    input  logic                sweep_start,
    output logic                step
`endif
);

    // A zero setting still spends one cycle in each timed state.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int RT_EFF     = (RDY_TIMEOUT < 1) ? 1 : RDY_TIMEOUT;
    localparam int RW         = $clog2(RT_EFF + 1);
    localparam int SW         = $clog2(SETTLE_EFF + 1);
    localparam logic [RW-1:0] RT_LOAD     = RW'(RT_EFF - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_EFF - 1);

    state_t           state;
    logic             accept;
    logic             start;
    logic             rdy_zero;
    logic             settle_zero;
    logic [TAP_W-1:0] rb_sel;
    logic             match;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign rb_sel        = (idelay_sel == LANE_CTL) ? idelay_value_out_ctl : idelay_value_out_data;
    assign match         = (rb_sel == idelay_value_in);

`ifdef RGMII_IDELAY_SWEEP_EN
    logic sweep_go;
    logic sweep_q;
    assign sweep_go = sweep_start && (state == ST_IDLE);
    assign start    = accept || sweep_go;
`else
    assign start    = accept;
`endif

    idelay_timer #(.W(RW)) u_rdy_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (RT_LOAD),
        .dec      (state == ST_WAIT_RDY),
        .zero     (rdy_zero)
    );

    idelay_timer #(.W(SW)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_LOAD),
        .load_val (SETTLE_LOAD),
        .dec      (state == ST_SETTLE),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            idelay_ld       <= '0;
            idelay_value_in <= '0;
            idelay_sel      <= '0;
            done            <= 1'b0;
            err             <= ERR_OK;
            readback        <= '0;
`ifdef RGMII_IDELAY_SWEEP_EN
            sweep_q         <= 1'b0;
            step            <= 1'b0;
`endif
        end else begin
            idelay_ld <= '0;
            done      <= 1'b0;
`ifdef RGMII_IDELAY_SWEEP_EN
            step      <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idelay_sel <= cmd.cmd_lane;
`ifdef RGMII_IDELAY_SWEEP_EN
                        idelay_value_in <= sweep_go ? '0 : cmd.cmd_value;
                        sweep_q         <= sweep_go;
`else
                        idelay_value_in <= cmd.cmd_value;
`endif
                        // Invalid lanes report through CHECK so busy shows for one cycle.
                        if (cmd.cmd_lane > LANE_CTL) begin
                            state <= ST_CHECK;
                            done  <= 1'b1;
                            err   <= ERR_LANE;
                        end else begin
                            state <= ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (idelayctrl_rdy) begin
                        state     <= ST_LOAD;
                        idelay_ld <= lane_onehot(idelay_sel);
                    end else if (rdy_zero) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        err   <= ERR_TIMEOUT;
                    end
                end
                ST_LOAD: state <= ST_SETTLE;
                ST_SETTLE: begin
                    // Readback is captured as CHECK is entered so done, err and readback align.
                    if (settle_zero) begin
                        state    <= ST_CHECK;
                        readback <= rb_sel;
                        err      <= match ? ERR_OK : ERR_MISMATCH;
`ifdef RGMII_IDELAY_SWEEP_EN
                        step     <= sweep_q;
                        done     <= !sweep_q || !match || (&idelay_value_in);
`else
                        done     <= 1'b1;
`endif
                    end
                end
                ST_CHECK: begin
`ifdef RGMII_IDELAY_SWEEP_EN
                    if (sweep_q && !done) begin
                        state           <= ST_LOAD;
                        idelay_value_in <= idelay_value_in + 1'b1;
                        idelay_ld       <= lane_onehot(idelay_sel);
                    end else begin
                        state   <= ST_IDLE;
                        sweep_q <= 1'b0;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_idelay_ctl.sv
// Directed testbench for rgmii_idelay_ctl (SETTLE_CYCLES=4, RDY_TIMEOUT=1023).
module tb_rgmii_idelay_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic [4:0] idelay_ld;
    logic [4:0] idelay_value_in;
    logic [2:0] idelay_sel;
    logic [4:0] out_data;
    logic [4:0] out_ctl;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [4:0] readback;
    logic       ctl_force_en = 1'b0;
    logic [4:0] ctl_force = 5'd0;
`ifdef RGMII_IDELAY_SWEEP_EN
    logic       sweep_start = 1'b0;
    logic       step;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rgmii_idelay_ctl_if cmd_if ();

    // Idealised IDELAY cells: readback echoes the presented tap unless overridden.
    assign out_data = idelay_value_in;
    assign out_ctl  = ctl_force_en ? ctl_force : idelay_value_in;

    rgmii_idelay_ctl dut (
        .clk                   (clk),
        .rst                   (rst),
        .idelayctrl_rdy        (rdy),
        .cmd                   (cmd_if),
        .idelay_ld             (idelay_ld),
        .idelay_value_in       (idelay_value_in),
        .idelay_sel            (idelay_sel),
        .idelay_value_out_data (out_data),
        .idelay_value_out_ctl  (out_ctl),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .readback              (readback)
`ifdef RGMII_IDELAY_SWEEP_EN
        ,
        .sweep_start           (sweep_start),
        .step                  (step)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one cycle; returns in cycle 1 after the accept.
    task automatic issue(input logic [2:0] lane, input logic [4:0] value);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_lane  = lane;
        cmd_if.cmd_value = value;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  c;
        bit  seen;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_lane  = 3'd0;
        cmd_if.cmd_value = 5'd0;

        // Reset state
        tick(); tick();
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ld", idelay_ld, 0);
        check("rst_value_in", idelay_value_in, 0);
        check("rst_sel", idelay_sel, 0);
        check("rst_err", err, 0);
        check("rst_readback", readback, 0);
        rst = 1'b0;
        tick();

        // Nominal: lane 2, value 17, rdy high
        rdy = 1'b1;
        issue(3'd2, 5'd17);
        check("nom_c1_busy", busy, 1);
        check("nom_c1_ready", cmd_if.cmd_ready, 0);
        check("nom_c1_value_in", idelay_value_in, 17);
        check("nom_c1_sel", idelay_sel, 2);
        check("nom_c1_ld", idelay_ld, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_lane  = 3'd3;
        cmd_if.cmd_value = 5'd2;
        tick();
        check("nom_c2_ld", idelay_ld, 5'b00100);
        tick();
        check("nom_c3_ld", idelay_ld, 0);
        check("busy_ignore_value", idelay_value_in, 17);
        check("busy_ignore_sel", idelay_sel, 2);
        cmd_if.cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("nom_c6_done", done, 0);
        tick();
        check("nom_c7_done", done, 1);
        check("nom_c7_err", err, 0);
        check("nom_c7_readback", readback, 17);
        tick();
        check("nom_c8_done", done, 0);
        check("nom_c8_busy", busy, 0);
        check("nom_c8_ready", cmd_if.cmd_ready, 1);

        // Ready timeout: lane 0 with rdy held low
        rdy = 1'b0;
        issue(3'd0, 5'd5);
        c = -1;
        seen = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            if (idelay_ld != 0) seen = 1'b1;
            if (done) begin
                c = i;
                break;
            end
            tick();
        end
        check("tmo_done_cycle", c, 1024);
        check("tmo_err", err, 2);
        check("tmo_no_ld", seen, 0);
        check("tmo_busy", busy, 0);
        tick();

        // Ctl lane mismatch: lane 4 value 9, ctl returns 8
        rdy = 1'b1;
        ctl_force_en = 1'b1;
        ctl_force = 5'd8;
        issue(3'd4, 5'd9);
        tick();
        check("ctl_c2_ld", idelay_ld, 5'b10000);
        repeat (5) tick();
        check("ctl_c7_done", done, 1);
        check("ctl_c7_err", err, 1);
        check("ctl_c7_readback", readback, 8);
        tick();
        ctl_force_en = 1'b0;

        // Invalid lane 6
        issue(3'd6, 5'd1);
        check("lane_c1_done", done, 1);
        check("lane_c1_err", err, 3);
        check("lane_c1_busy", busy, 1);
        check("lane_c1_ld", idelay_ld, 0);
        tick();
        check("lane_c2_busy", busy, 0);
        check("lane_c2_done", done, 0);
        check("lane_c2_err_sticky", err, 3);

        // Reset during SETTLE
        issue(3'd0, 5'd7);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rsts_busy", busy, 0);
        check("rsts_done", done, 0);
        check("rsts_ld", idelay_ld, 0);
        check("rsts_value_in", idelay_value_in, 0);
        check("rsts_sel", idelay_sel, 0);
        check("rsts_err", err, 0);
        check("rsts_readback", readback, 0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (done) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (8) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("rsts_no_done", seen, 0);

        // Reset during LOAD drops the strobe at once
        issue(3'd0, 5'd7);
        tick();
        check("rstl_ld_before", idelay_ld, 5'b00001);
        rst = 1'b1;
        #1;
        check("rstl_ld_dropped", idelay_ld, 0);
        tick();
        rst = 1'b0;
        tick();

        // Lane 1 value 3, rdy drops during SETTLE
        issue(3'd1, 5'd3);
        tick();
        check("l1_c2_ld", idelay_ld, 5'b00010);
        tick();
        rdy = 1'b0;
        repeat (4) tick();
        check("l1_c7_done", done, 1);
        check("l1_c7_err", err, 0);
        check("l1_c7_readback", readback, 3);
        rdy = 1'b1;
        tick();

`ifdef RGMII_IDELAY_SWEEP_EN
        begin
            int k;
            int nd;
            int done_k;
            k = 0;
            nd = 0;
            done_k = -1;
            cmd_if.cmd_lane = 3'd3;
            sweep_start = 1'b1;
            tick();
            sweep_start = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if (step) begin
                    check("sweep_tap", idelay_value_in, k);
                    k++;
                end
                if (done) begin
                    nd++;
                    done_k = k;
                end
                tick();
            end
            check("sweep_steps", k, 32);
            check("sweep_dones", nd, 1);
            check("sweep_done_at_last", done_k, 32);
            check("sweep_err", err, 0);
            check("sweep_sel", idelay_sel, 3);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
